input_conditioner: RTL and testbench
====================================

# input_conditioner

Multi-channel input conditioner for push-buttons and switches, the parametrised successor to the lab debouncer. Each channel passes through a synchroniser, then a shared sample timer and a per-channel up/down saturating counter with hysteresis. The block produces a clean level plus one-cycle rise/fall pulses for downstream FSMs. It sits directly behind the board pins, ahead of any logic that consumes button or switch events.

## Interface

- `WIDTH`, 1: number of independent channels.
- `SAMPLE_CNT_MAX`, 62500: clock cycles per sample tick; must be ≥ 2.
- `PULSE_CNT_MAX`, 200: counter saturation value in sample ticks; must be ≥ 1.
- `SYNC_STAGES`, 2: synchroniser depth; must be ≥ 2.
- `FAST_RELEASE`, 0: release mode. 0 selects symmetric hysteresis; 1 selects legacy behaviour, where any sampled 0 clears the channel.
- `LONG_CNT_MAX`, 1000: long-press threshold in sample ticks. Used only with `INPUT_CONDITIONER_LONG_PRESS_EN`.

- `clk`, in, 1: single clock; all state is on its rising edge.
- `rst_n`, in, 1: synchronous, active-low reset.
- `glitchy_signal`, in, `WIDTH`: raw asynchronous inputs.
- `debounced_signal`, out, `WIDTH`: conditioned level, registered.
- `rise_pulse`, out, `WIDTH`: one-cycle pulse marking a 0→1 change of `debounced_signal`.
- `fall_pulse`, out, `WIDTH`: one-cycle pulse marking a 1→0 change of `debounced_signal`.
- `long_press`, out, `WIDTH`: present only with the macro; one-cycle pulse.

## Operation

- **Synchroniser:** per channel, a chain of `SYNC_STAGES` flops; the last stage is `sync[i]`.
- **Sample timer:** one shared counter running 0..`SAMPLE_CNT_MAX`-1, width `$clog2(SAMPLE_CNT_MAX)`.
  - `tick` is high for the single cycle in which the counter equals `SAMPLE_CNT_MAX`-1.
  - After that value the counter wraps to 0.
- **Channel counter** `cnt[i]`: range 0..`PULSE_CNT_MAX`, width `$clog2(PULSE_CNT_MAX+1)`. It changes only on `tick`.
  - `sync[i]`=1 and `cnt`<MAX: `cnt`+1.
  - `sync[i]`=0: with `FAST_RELEASE`=0, `cnt`-1 if `cnt`>0; with `FAST_RELEASE`=1, `cnt`←0.
  - The counter saturates at both ends and never wraps.
- **Level:**
  - `debounced_signal[i]` sets when `cnt_next`==`PULSE_CNT_MAX`.
  - It clears when `cnt_next`==0.
  - Otherwise it holds (hysteresis band).
- **Edges:** registered in parallel with the level.
  - `rise_q` ← `deb_next` & ~`deb`.
  - `fall_q` ← ~`deb_next` & `deb`.
  - Each pulse is therefore high in exactly the first cycle the new level is visible.
- Channels are fully independent; events on different channels in the same cycle do not interact.

## Timing

- **Reset:** with `rst_n` low at a rising edge, all of the following become 0:
  - synchroniser flops, sample timer, all `cnt`;
  - `debounced_signal`, `rise_pulse`, `fall_pulse`, `long_press`;
  - long-press counters.
- **Reset mid-operation:** same result; no pulse is emitted on entry to or exit from reset.
- **Input-to-sample latency:** `SYNC_STAGES` cycles.
- **Press latency:** for a channel at `cnt`=0 with the input held high, `debounced_signal` rises between (`PULSE_CNT_MAX`-1)·`SAMPLE_CNT_MAX`+`SYNC_STAGES`+1 and `PULSE_CNT_MAX`·`SAMPLE_CNT_MAX`+`SYNC_STAGES`+1 cycles after the input change.
- **Release latency:**
  - Symmetric mode: the same bound as press, measured from `cnt`=MAX.
  - `FAST_RELEASE`=1: at most `SAMPLE_CNT_MAX`+`SYNC_STAGES`+1 cycles.
- **Glitch rejection:** an input that never holds long enough for `cnt` to reach MAX produces no change on the level and no pulses.
- **Pulse width:** rise/fall pulses are exactly 1 cycle. Consecutive pulses on one channel are separated by at least `SAMPLE_CNT_MAX` cycles.

## Configuration

- **Macro:** `INPUT_CONDITIONER_LONG_PRESS_EN`.
- **Defined:**
  - Each channel gets a tick counter, range 0..`LONG_CNT_MAX`, that increments on `tick` while `debounced_signal[i]`=1 and saturates at `LONG_CNT_MAX`.
  - The counter clears in the cycle `debounced_signal[i]` falls.
  - `long_press[i]` pulses for 1 cycle when the counter reaches `LONG_CNT_MAX`, at most once per press.
- **Undefined:** the `long_press` port and all of its logic are absent. All other behaviour is identical.

## Test plan

Bench parameters: `WIDTH`=2, `SAMPLE_CNT_MAX`=10, `PULSE_CNT_MAX`=4, `SYNC_STAGES`=2, clk period 8 ns.

- **Reset:** `rst_n`=0 for 5 cycles with `glitchy_signal`=2'b11, then release → all outputs 0 during reset and for at least 30 cycles after.
  - Pulling `rst_n` low again while `debounced_signal`=1 → that output is 0 one cycle later, with no `fall_pulse`.
- **Glitch rejection:** ch0 toggled every cycle for 10 cycles, then low 11 cycles, high 30 cycles, low 50 cycles → `debounced_signal[0]` and `rise_pulse[0]` are never 1.
- **Press:** ch1 toggled for 10 cycles, then held high 50 cycles → `debounced_signal[1]`=1 by cycle 50. `rise_pulse[1]` is high for exactly 1 cycle. The level stays 1 for the next 30 cycles.
- **Symmetric release** (`FAST_RELEASE`=0): ch1 driven low → level stays 1 for at least 30 cycles, is 0 by cycle 50, `fall_pulse[1]` is high for exactly 1 cycle, and the level stays 0 for a further 50 cycles.
- **Fast release** (`FAST_RELEASE`=1): repeat the press, then drive ch1 low → level is 0 within 13 cycles with a single `fall_pulse[1]`.
- **Long press** (macro defined, `LONG_CNT_MAX`=5): hold ch1 high for 150 cycles → `long_press[1]` pulses once, 50±10 cycles after `rise_pulse[1]`. Repeating with the macro undefined → the design compiles without the `long_press` port.

Source files
------------

// File: rtl/input_conditioner.sv
// -----------------------------------------------------------------------------
// input_conditioner
//
// Multi-channel debouncer for push-buttons and switches. Each channel is
// synchronised and then sampled on a shared tick. A per-channel saturating
// up/down counter, read through a hysteresis band, decides the clean level.
// The block emits the registered level plus one-cycle rise/fall pulses.
//
// Optional feature macro: INPUT_CONDITIONER_LONG_PRESS_EN
//   When defined, adds a per-channel long-press counter and the long_press
//   output. When undefined, that port and its logic do not exist.
//
// Parameters
//   WIDTH          number of independent channels
//   SAMPLE_CNT_MAX clock cycles per sample tick (>= 2)
//   PULSE_CNT_MAX  counter saturation value in ticks (>= 1)
//   SYNC_STAGES    synchroniser depth (>= 2)
//   FAST_RELEASE   0: symmetric hysteresis, 1: any sampled 0 clears the channel
//   LONG_CNT_MAX   long-press threshold in ticks (long-press build only)
//
// Ports
//   clk              rising-edge clock for all state
//   rst_n            synchronous active-low reset
//   glitchy_signal   [WIDTH] raw asynchronous inputs
//   debounced_signal [WIDTH] conditioned level, registered
//   rise_pulse       [WIDTH] one-cycle pulse on 0->1 of debounced_signal
//   fall_pulse       [WIDTH] one-cycle pulse on 1->0 of debounced_signal
//   long_press       [WIDTH] one-cycle pulse when a press reaches LONG_CNT_MAX
//                            ticks (long-press build only)
// -----------------------------------------------------------------------------
module input_conditioner #(
  parameter int WIDTH          = 1,
  parameter int SAMPLE_CNT_MAX = 62500,
  parameter int PULSE_CNT_MAX  = 200,
  parameter int SYNC_STAGES    = 2,
  parameter int FAST_RELEASE   = 0,
  parameter int LONG_CNT_MAX   = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] glitchy_signal,
  output logic [WIDTH-1:0] debounced_signal,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse
`ifdef INPUT_CONDITIONER_LONG_PRESS_EN
  ,
  output logic [WIDTH-1:0] long_press
`endif
);

  // Elaboration-time parameter legality checks.
  if (SAMPLE_CNT_MAX < 2) begin : g_bad_sample
    $error("input_conditioner: SAMPLE_CNT_MAX must be >= 2");
  end
  if (PULSE_CNT_MAX < 1) begin : g_bad_pulse
    $error("input_conditioner: PULSE_CNT_MAX must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("input_conditioner: SYNC_STAGES must be >= 2");
  end
  if (LONG_CNT_MAX < 1) begin : g_bad_long
    $error("input_conditioner: LONG_CNT_MAX must be >= 1");
  end

  localparam int TW = $clog2(SAMPLE_CNT_MAX);
  localparam int CW = $clog2(PULSE_CNT_MAX + 1);

  localparam logic [TW-1:0] TIMER_LAST = TW'(SAMPLE_CNT_MAX - 1);
  localparam logic [CW-1:0] CNT_MAX    = CW'(PULSE_CNT_MAX);

  // One sample-tick update of a channel counter. Saturates at both ends;
  // in fast-release mode a low sample drops straight to zero.
  function automatic logic [CW-1:0] sat_step(input logic [CW-1:0] cur,
                                             input logic          up);
    logic [CW-1:0] res;
    res = cur;
    if (up) begin
      if (cur != CNT_MAX) res = cur + CW'(1);
    end else if (FAST_RELEASE != 0) begin
      res = '0;
    end else if (cur != '0) begin
      res = cur - CW'(1);
    end
    return res;
  endfunction

  // Hysteresis: only the two end points of the counter move the level.
  function automatic logic level_next(input logic [CW-1:0] cnt,
                                      input logic          cur_level);
    logic res;
    res = cur_level;
    if (cnt == CNT_MAX)  res = 1'b1;
    else if (cnt == '0)  res = 1'b0;
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // Stage p0: synchroniser chain; sync_p0[SYNC_STAGES-1] is the usable sample
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] sync_p0 [SYNC_STAGES];
  logic [WIDTH-1:0] sync_last;

  assign sync_last = sync_p0[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_p0[s] <= '0;
    end else begin
      sync_p0[0] <= glitchy_signal;
      for (int s = 1; s < SYNC_STAGES; s++) sync_p0[s] <= sync_p0[s-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p1: shared sample timer and per-channel saturating counters
  // ---------------------------------------------------------------------------
  logic [TW-1:0] timer_p1;
  logic          tick;
  logic [CW-1:0] cnt_p1   [WIDTH];
  logic [CW-1:0] cnt_next [WIDTH];

  assign tick = (timer_p1 == TIMER_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer_p1 <= '0;
    end else if (tick) begin
      timer_p1 <= '0;
    end else begin
      timer_p1 <= timer_p1 + TW'(1);
    end
  end

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      cnt_next[i] = cnt_p1[i];
      if (tick) cnt_next[i] = sat_step(cnt_p1[i], sync_last[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) cnt_p1[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) cnt_p1[i] <= cnt_next[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p2: level and edge pulses, all registered together so each pulse
  // coincides with the first cycle the new level is visible
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] deb_p2;
  logic [WIDTH-1:0] rise_p2;
  logic [WIDTH-1:0] fall_p2;
  logic [WIDTH-1:0] deb_next;

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      deb_next[i] = level_next(cnt_next[i], deb_p2[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      deb_p2  <= '0;
      rise_p2 <= '0;
      fall_p2 <= '0;
    end else begin
      deb_p2  <= deb_next;
      rise_p2 <= deb_next & ~deb_p2;
      fall_p2 <= ~deb_next & deb_p2;
    end
  end

  assign debounced_signal = deb_p2;
  assign rise_pulse       = rise_p2;
  assign fall_pulse       = fall_p2;

`ifdef INPUT_CONDITIONER_LONG_PRESS_EN
  // ---------------------------------------------------------------------------
  // Stage p2 (long press): counts ticks while the level is high; the pulse
  // fires on the transition into saturation, so at most once per press
  // ---------------------------------------------------------------------------
  localparam int LW = $clog2(LONG_CNT_MAX + 1);
  localparam logic [LW-1:0] LONG_MAX = LW'(LONG_CNT_MAX);

  logic [LW-1:0]    long_cnt_p2   [WIDTH];
  logic [LW-1:0]    long_cnt_next [WIDTH];
  logic [WIDTH-1:0] long_p2;
  logic [WIDTH-1:0] long_hit;

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      long_cnt_next[i] = long_cnt_p2[i];
      long_hit[i]      = 1'b0;
      if (!deb_next[i]) begin
        long_cnt_next[i] = '0;
      end else if (tick && deb_p2[i] && (long_cnt_p2[i] != LONG_MAX)) begin
        long_cnt_next[i] = long_cnt_p2[i] + LW'(1);
        long_hit[i]      = (long_cnt_p2[i] + LW'(1)) == LONG_MAX;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) long_cnt_p2[i] <= '0;
      long_p2 <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) long_cnt_p2[i] <= long_cnt_next[i];
      long_p2 <= long_hit;
    end
  end

  assign long_press = long_p2;
`endif

endmodule

// File: tb/tb_input_conditioner.sv
module tb_input_conditioner;

  localparam int W     = 2;
  localparam int SMAX  = 10;
  localparam int PMAX  = 4;
  localparam int SYNC  = 2;
  localparam int LMAX  = 5;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] glitchy;

  logic [W-1:0] deb_s, rise_s, fall_s;   // symmetric-release instance
  logic [W-1:0] deb_f, rise_f, fall_f;   // fast-release instance
`ifdef INPUT_CONDITIONER_LONG_PRESS_EN
  logic [W-1:0] long_s, long_f;
`endif

  always #4 clk = ~clk;

  input_conditioner #(
    .WIDTH(W), .SAMPLE_CNT_MAX(SMAX), .PULSE_CNT_MAX(PMAX),
    .SYNC_STAGES(SYNC), .FAST_RELEASE(0), .LONG_CNT_MAX(LMAX)
  ) u_sym (
    .clk(clk), .rst_n(rst_n), .glitchy_signal(glitchy),
    .debounced_signal(deb_s), .rise_pulse(rise_s), .fall_pulse(fall_s)
`ifdef INPUT_CONDITIONER_LONG_PRESS_EN
    , .long_press(long_s)
`endif
  );

  input_conditioner #(
    .WIDTH(W), .SAMPLE_CNT_MAX(SMAX), .PULSE_CNT_MAX(PMAX),
    .SYNC_STAGES(SYNC), .FAST_RELEASE(1), .LONG_CNT_MAX(LMAX)
  ) u_fast (
    .clk(clk), .rst_n(rst_n), .glitchy_signal(glitchy),
    .debounced_signal(deb_f), .rise_pulse(rise_f), .fall_pulse(fall_f)
`ifdef INPUT_CONDITIONER_LONG_PRESS_EN
    , .long_press(long_f)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model. Index f selects release mode (0 symmetric, 1 fast).
  // Sample seen at an edge = input captured SYNC edges earlier (0 if that
  // capture happened in reset); ticks fall on every SMAX-th edge after reset.
  // ---------------------------------------------------------------------------
  logic [W-1:0] m_lev  [2];
  logic [W-1:0] m_rise [2];
  logic [W-1:0] m_fall [2];
  logic [W-1:0] m_long [2];
  int           m_cnt  [2][W];
  int           m_lcnt [2][W];
  logic [W-1:0] m_hist [$];
  int           m_run;

  initial begin
    logic [W-1:0] samp;
    bit           tk;
    logic         old, nl;
    for (int f = 0; f < 2; f++) begin
      m_lev[f] = '0; m_rise[f] = '0; m_fall[f] = '0; m_long[f] = '0;
      for (int c = 0; c < W; c++) begin m_cnt[f][c] = 0; m_lcnt[f][c] = 0; end
    end
    m_run = 0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        for (int f = 0; f < 2; f++) begin
          m_lev[f] = '0; m_rise[f] = '0; m_fall[f] = '0; m_long[f] = '0;
          for (int c = 0; c < W; c++) begin m_cnt[f][c] = 0; m_lcnt[f][c] = 0; end
        end
        m_hist.delete();
        for (int s = 0; s < SYNC; s++) m_hist.push_back('0);
        m_run = 0;
      end else begin
        samp = m_hist[0];
        tk   = (m_run % SMAX) == (SMAX - 1);
        m_run++;
        m_hist.push_back(glitchy);
        void'(m_hist.pop_front());
        for (int f = 0; f < 2; f++) begin
          m_long[f] = '0;
          for (int c = 0; c < W; c++) begin
            old = m_lev[f][c];
            if (tk) begin
              if (samp[c])     m_cnt[f][c] = (m_cnt[f][c] < PMAX) ? m_cnt[f][c] + 1 : PMAX;
              else if (f == 1) m_cnt[f][c] = 0;
              else             m_cnt[f][c] = (m_cnt[f][c] > 0) ? m_cnt[f][c] - 1 : 0;
            end
            nl = (m_cnt[f][c] == PMAX) ? 1'b1 : (m_cnt[f][c] == 0) ? 1'b0 : old;
            m_rise[f][c] = nl & ~old;
            m_fall[f][c] = ~nl & old;
            m_lev[f][c]  = nl;
            if (!nl) m_lcnt[f][c] = 0;
            else if (tk && old && m_lcnt[f][c] < LMAX) begin
              m_lcnt[f][c]++;
              if (m_lcnt[f][c] == LMAX) m_long[f][c] = 1'b1;
            end
          end
        end
      end
    end
  end

  // Cycle-by-cycle comparison of both instances against the model.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("sym_level", deb_s,  m_lev[0]);
      check("sym_rise",  rise_s, m_rise[0]);
      check("sym_fall",  fall_s, m_fall[0]);
      check("fast_level", deb_f,  m_lev[1]);
      check("fast_rise",  rise_f, m_rise[1]);
      check("fast_fall",  fall_f, m_fall[1]);
`ifdef INPUT_CONDITIONER_LONG_PRESS_EN
      check("sym_long",  long_s, m_long[0]);
      check("fast_long", long_f, m_long[1]);
`endif
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic any_out();
    return |{deb_s, rise_s, fall_s, deb_f, rise_f, fall_f};
  endfunction

  // ---------------------------------------------------------------------------
  // Directed scenarios followed by random traffic
  // ---------------------------------------------------------------------------
  initial begin
    int bad, nrise_s, nrise_f, nfall_s, nfall_f, low_s, t_rise, t_long, nlong;
    rst_n   = 1'b0;
    glitchy = 2'b11;

    // Reset with inputs high, then quiet period after release.
    bad = 0;
    for (int k = 0; k < 5; k++) begin step(); if (any_out()) bad++; end
    check("reset_outputs_zero", bad, 0);
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 30; k++) begin step(); if (any_out()) bad++; end
    check("post_reset_quiet_30", bad, 0);
    repeat (25) step();
    check("held_both_high_sym",  deb_s, 2'b11);
    check("held_both_high_fast", deb_f, 2'b11);
    check("model_both_high", m_lev[0], 2'b11);

    // Reset while the level is high: drops next cycle with no fall pulse.
    rst_n = 1'b0;
    step();
    check("midreset_level_sym",  deb_s, 2'b00);
    check("midreset_fall_sym",   fall_s, 2'b00);
    check("midreset_level_fast", deb_f, 2'b00);
    check("midreset_fall_fast",  fall_f, 2'b00);
    glitchy = 2'b00;
    repeat (3) step();
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 20; k++) begin step(); if (any_out()) bad++; end
    check("reset_exit_no_pulse", bad, 0);

    // Glitch rejection on ch0.
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      glitchy[0] = ~glitchy[0]; step();
      if (deb_s[0] | rise_s[0] | deb_f[0] | rise_f[0]) bad++;
    end
    glitchy[0] = 1'b0;
    for (int k = 0; k < 11; k++) begin step(); if (deb_s[0] | rise_s[0] | deb_f[0] | rise_f[0]) bad++; end
    glitchy[0] = 1'b1;
    for (int k = 0; k < 30; k++) begin step(); if (deb_s[0] | rise_s[0] | deb_f[0] | rise_f[0]) bad++; end
    glitchy[0] = 1'b0;
    for (int k = 0; k < 50; k++) begin step(); if (deb_s[0] | rise_s[0] | deb_f[0] | rise_f[0]) bad++; end
    check("glitch_rejected_ch0", bad, 0);
    check("model_glitch_level", m_lev[0][0], 1'b0);

    // Press on ch1 after a bouncy start.
    nrise_s = 0; nrise_f = 0;
    for (int k = 0; k < 10; k++) begin
      glitchy[1] = ~glitchy[1]; step();
      nrise_s += int'(rise_s[1]); nrise_f += int'(rise_f[1]);
    end
    glitchy[1] = 1'b1;
    for (int k = 0; k < 50; k++) begin
      step(); nrise_s += int'(rise_s[1]); nrise_f += int'(rise_f[1]);
    end
    check("press_level_by_50_sym",  deb_s[1], 1'b1);
    check("press_level_by_50_fast", deb_f[1], 1'b1);
    check("model_press_level", m_lev[0][1], 1'b1);
    low_s = 0;
    for (int k = 0; k < 30; k++) begin
      step(); nrise_s += int'(rise_s[1]); nrise_f += int'(rise_f[1]);
      if (!deb_s[1] || !deb_f[1]) low_s++;
    end
    check("press_single_rise_sym",  nrise_s, 1);
    check("press_single_rise_fast", nrise_f, 1);
    check("press_level_holds_30", low_s, 0);

    // Release on ch1: symmetric holds >=30 cycles, fast drops within 13.
    glitchy[1] = 1'b0;
    nfall_s = 0; nfall_f = 0; low_s = 0;
    for (int k = 1; k <= 50; k++) begin
      step(); nfall_s += int'(fall_s[1]); nfall_f += int'(fall_f[1]);
      if (k <= 30 && !deb_s[1]) low_s++;
      if (k == 13) check("fast_release_by_13", deb_f[1], 1'b0);
    end
    check("sym_release_holds_30", low_s, 0);
    check("sym_release_by_50", deb_s[1], 1'b0);
    check("model_release_level", m_lev[0][1], 1'b0);
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      step(); nfall_s += int'(fall_s[1]); nfall_f += int'(fall_f[1]);
      if (deb_s[1] || deb_f[1]) bad++;
    end
    check("sym_single_fall",  nfall_s, 1);
    check("fast_single_fall", nfall_f, 1);
    check("release_stays_low_50", bad, 0);

`ifdef INPUT_CONDITIONER_LONG_PRESS_EN
    // Long press on ch1.
    glitchy[1] = 1'b1;
    t_rise = -1000; t_long = 0; nlong = 0;
    for (int k = 0; k < 150; k++) begin
      step();
      if (rise_s[1]) t_rise = k;
      if (long_s[1]) begin nlong++; t_long = k; end
    end
    check("long_press_once", nlong, 1);
    check("long_press_delay_50pm10",
          32'((t_long - t_rise >= 40) && (t_long - t_rise <= 60)), 32'd1);
    glitchy[1] = 1'b0;
    repeat (60) step();
`else
    t_rise = 0; t_long = 0; nlong = 0;
`endif

    // Random traffic with occasional resets; model checks every cycle.
    for (int seg = 0; seg < 40; seg++) begin
      if ($urandom_range(0, 15) == 0) begin
        rst_n = 1'b0;
        repeat ($urandom_range(1, 3)) step();
        rst_n = 1'b1;
      end
      glitchy = W'($urandom_range(0, 3));
      repeat ($urandom_range(1, 55)) step();
    end
    repeat (60) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
